// File: rtl/alu_exec_unit.sv
// Integer/branch/JALR execution stage: computes one op per cycle and queues the
// result in a small in-order buffer that drains onto the CDB under a grant.
module alu_exec_unit #(
  parameter int DEPTH = 2,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [ROB_W-1:0] in_rob,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ROB_W-1:0] out_rob,
  output logic [31:0]      out_val,
  output logic             out_br,
  output logic             out_taken,
  output logic             out_illegal,
  input  logic             cdb_grant
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(15);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(16);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(17);

  logic [31:0] res_val;
  logic        res_br;
  logic        res_taken;
  logic        res_ill;
  logic [4:0]  sh;
  logic [31:0] sum;
  logic        lt_s;
  logic        lt_u;

  assign sh   = in_b[4:0];
  assign sum  = in_a + in_b;
  assign lt_s = $signed(in_a) < $signed(in_b);
  assign lt_u = in_a < in_b;

  always_comb begin
    res_val   = '0;
    res_br    = 1'b0;
    res_taken = 1'b0;
    res_ill   = 1'b0;
    case (in_op)
      OP_ADD:  res_val = sum;
      OP_SUB:  res_val = in_a - in_b;
      OP_SLL:  res_val = in_a << sh;
      OP_SLT:  res_val = {31'b0, lt_s};
      OP_SLTU: res_val = {31'b0, lt_u};
      OP_XOR:  res_val = in_a ^ in_b;
      OP_SRL:  res_val = in_a >> sh;
      OP_SRA:  res_val = $unsigned($signed(in_a) >>> sh);
      OP_OR:   res_val = in_a | in_b;
      OP_AND:  res_val = in_a & in_b;
      OP_BEQ:  begin res_br = 1'b1; res_taken = (in_a == in_b); end
      OP_BNE:  begin res_br = 1'b1; res_taken = (in_a != in_b); end
      OP_BLT:  begin res_br = 1'b1; res_taken = lt_s;  end
      OP_BGE:  begin res_br = 1'b1; res_taken = !lt_s; end
      OP_BLTU: begin res_br = 1'b1; res_taken = lt_u;  end
      OP_BGEU: begin res_br = 1'b1; res_taken = !lt_u; end
      OP_JALR: res_val = {sum[31:1], 1'b0};
      default: res_ill = 1'b1;
    endcase
  end

  // Handshake: an op transfers on an edge where in_valid & in_ready (rdy=1,
  // flush=0); the head transfers where out_valid & cdb_grant (rdy=1, flush=0).
  // in_ready depends only on buffer occupancy, never on in_valid.
  logic [ROB_W-1:0] rob_mem   [DEPTH];
  logic [31:0]      val_mem   [DEPTH];
  logic             br_mem    [DEPTH];
  logic             taken_mem [DEPTH];
  logic             ill_mem   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push = in_valid & in_ready & rdy & !flush;
  assign pop  = out_valid & cdb_grant & rdy & !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (rdy) begin
      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: an entry is only visible while counted.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      rob_mem[tail]   <= in_rob;
      val_mem[tail]   <= res_val;
      br_mem[tail]    <= res_br;
      taken_mem[tail] <= res_taken;
      ill_mem[tail]   <= res_ill;
    end
  end

  always_comb begin
    out_rob     = '0;
    out_val     = '0;
    out_br      = 1'b0;
    out_taken   = 1'b0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_rob     = rob_mem[head];
      out_val     = val_mem[head];
      out_br      = br_mem[head];
      out_taken   = taken_mem[head];
      out_illegal = ill_mem[head];
    end
  end

endmodule
